// File: rtl/ln_cordic_pkg.sv
// ln_cordic_pkg: shared constants and types for the ln(a) CORDIC controller.
//   Q_W        - width of every signed Q7.25 datum
//   ONE        - 1.0 in Q7.25
//   A_MIN_DEF  - default lowest legal operand (0.11)
//   A_MAX_DEF  - default highest legal operand (9.0)
//   tag_t      - per-operation tag travelling alongside the CORDIC pipeline
//   result_t   - one result buffer entry {err, ln}
package ln_cordic_pkg;

    localparam int Q_W   = 32;
    localparam int RES_W = Q_W + 1;

    localparam logic signed [Q_W-1:0] ONE       = 32'sh0200_0000;
    localparam logic signed [Q_W-1:0] A_MIN_DEF = 32'sh0038_51EB;
    localparam logic signed [Q_W-1:0] A_MAX_DEF = 32'sh1200_0000;

    typedef struct packed {
        logic valid;
        logic err;
    } tag_t;

    typedef struct packed {
        logic           err;
        logic [Q_W-1:0] ln;
    } result_t;

endpackage

// File: rtl/ln_result_fifo.sv
// ln_result_fifo: small synchronous FIFO holding finished ln results.
//   clk, rst_n  - clock and asynchronous active-low reset
//   wr_en       - push wr_data (caller guarantees the FIFO is not full)
//   wr_data     - entry to push
//   rd_en       - pop the head entry (ignored when empty)
//   rd_data     - current head entry (meaningless while empty)
//   empty       - no entries stored
//   count       - number of entries stored
module ln_result_fifo
    import ln_cordic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = RES_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd;

    // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; empty/count gate every use of stale entries,
    // and leaving it unreset keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_next(wr_ptr);
            if (do_rd) rd_ptr <= ptr_next(rd_ptr);
            case ({wr_en, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ln_cordic_ctrl.sv
// ln_cordic_ctrl: drives an external hyperbolic CORDIC (thv_cordic) to compute
// ln(a) = 2*atanh((a-1)/(a+1)), tracks each operation with a tag delayed by the
// CORDIC latency and buffers results in a credit-controlled FIFO.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - operand handshake, in_a is the Q7.25 operand
//   cor_x, cor_y         - CORDIC x/y inputs (a+1, a-1; zero when idle/illegal)
//   cor_z                - CORDIC z output, LATENCY cycles after x/y
//   out_valid/out_ready  - result handshake, out_ln = ln(a), out_err = range error
//   busy                 - operations in flight or buffered
module ln_cordic_ctrl
    import ln_cordic_pkg::*;
#(
    parameter int                    LATENCY = 16,
    parameter int                    DEPTH   = 4,
    parameter logic signed [Q_W-1:0] A_MIN   = A_MIN_DEF,
    parameter logic signed [Q_W-1:0] A_MAX   = A_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_a,
    output logic [Q_W-1:0] cor_x,
    output logic [Q_W-1:0] cor_y,
    input  logic [Q_W-1:0] cor_z,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] out_ln,
    output logic           out_err,
    output logic           busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic             ready_en;
    logic             accept;
    logic             legal;
    tag_t             tag_q;
    tag_t             tag_sr [LATENCY];
    tag_t             tag_out;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credits_used;
    logic             fifo_wr;
    logic             fifo_empty;
    logic             pop;
    result_t          wr_res;
    result_t          head;

    // Asynchronous assert, synchronous release. ready_en duplicates the second
    // stage so the internal reset net is never also used as data.
    // NOTE: sequential state is assigned with <= so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= '0;
            ready_en <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            ready_en <= rst_sync[0];
        end
    end
    assign rst_int_n = rst_sync[1];

    assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready     = ready_en & (credits_used < (CNT_W + 1)'(DEPTH));
    assign accept       = in_valid & in_ready;
    assign legal        = ($signed(in_a) >= A_MIN) && ($signed(in_a) <= A_MAX);

    // tag_q is issued alongside cor_x/cor_y, then delayed LATENCY cycles so it
    // exits exactly when cor_z holds the matching CORDIC result.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cor_x <= '0;
            cor_y <= '0;
            tag_q <= '0;
        end else begin
            tag_q <= '{valid: accept, err: accept & ~legal};
            if (accept && legal) begin
                cor_x <= in_a + ONE;
                cor_y <= in_a - ONE;
            end else begin
                cor_x <= '0;
                cor_y <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < LATENCY; i++) tag_sr[i] <= '0;
        end else begin
            tag_sr[0] <= tag_q;
            for (int i = 1; i < LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
        end
    end
    assign tag_out = tag_sr[LATENCY-1];
    assign fifo_wr = tag_out.valid;

    // ln = 2*z; out-of-range operands report ln = 0.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_res     = '0;
        wr_res.err = tag_out.err;
        if (!tag_out.err) wr_res.ln = {cor_z[Q_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            inflight <= '0;
        end else begin
            case ({accept, fifo_wr})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    ln_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .wr_en   (fifo_wr),
        .wr_data (wr_res),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    assign out_ln    = fifo_empty ? '0 : head.ln;
    assign out_err   = ~fifo_empty & head.err;
    assign busy      = (inflight != '0) | (fifo_count != '0);

endmodule
